// File: rtl/sbd_sqrt_fp_pkg.sv
// Shared definitions for the round-robin sqrt arbiter: state encoding,
// default datapath width and the nominal sqrt unit latency.
package sbd_sqrt_fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int SQRT_LAT  = 27;

endpackage

// File: rtl/sbd_sqrt_fp_arbiter_if.sv
// Requester and sqrt-unit handshake bundle; the arbiter sits on the slave
// modport, requesters plus the sqrt datapath form the master side.
interface sbd_sqrt_fp_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       REQ_VAL;
    logic [NREQ*WIDTH-1:0] REQ_DATA;
    logic [NREQ-1:0]       REQ_RDY;
    logic [NREQ-1:0]       RSP_VAL;
    logic [NREQ-1:0]       RSP_RDY;
    logic [WIDTH-1:0]      RSP_DATA;
    logic                  SQ_VAL_IN;
    logic [WIDTH-1:0]      SQ_DATA_IN;
    logic                  SQ_VAL_OUT;
    logic [WIDTH-1:0]      SQ_DATA_OUT;

    modport master (
        output REQ_VAL, REQ_DATA, RSP_RDY, SQ_VAL_OUT, SQ_DATA_OUT,
        input  REQ_RDY, RSP_VAL, RSP_DATA, SQ_VAL_IN, SQ_DATA_IN
    );

    modport slave (
        input  REQ_VAL, REQ_DATA, RSP_RDY, SQ_VAL_OUT, SQ_DATA_OUT,
        output REQ_RDY, RSP_VAL, RSP_DATA, SQ_VAL_IN, SQ_DATA_IN
    );
endinterface

// File: rtl/sbd_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping around; returns a one-hot grant and a valid flag.
module sbd_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            vld_o
);
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        vld_o = found;
    end
endmodule

// File: rtl/sbd_sqrt_fp_arbiter.sv
// Shares one sqrt unit between NREQ requesters, one operation at a time.
// Optional watchdog on the WAIT state: define SBD_SQRT_ARB_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | arbitrate, accept one operand from the round-robin winner
// ST_ISSUE | one-cycle start pulse to the sqrt unit
// ST_WAIT  | operand held, waiting for the sqrt result
// ST_RESP  | result offered to the granted requester until accepted
// ST_GAP   | idle cycle so the sqrt unit's valid clears before restart
module sbd_sqrt_fp_arbiter
    import sbd_sqrt_fp_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TMO_CYC = 63
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    sbd_sqrt_fp_arbiter_if.slave bus,
    output logic                 BUSY,
    output logic                 ERR
);
    localparam int PW = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic [NREQ-1:0]  pick_gnt;
    logic             pick_vld;
    logic [PW-1:0]    win_idx;
    logic             tmo_hit;

    sbd_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i (bus.REQ_VAL),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .vld_o (pick_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_gnt[k]) win_idx = PW'(k);
        end
    end

`ifdef SBD_SQRT_ARB_TIMEOUT_EN
    // cnt_q + 1 equals the number of WAIT cycles elapsed so far
    localparam logic [6:0] TMO_LIM = 7'(TMO_CYC - 1);
    logic [6:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    assign tmo_hit = (state_q == ST_WAIT) && !bus.SQ_VAL_OUT && (cnt_q == TMO_LIM);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == ST_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT && !bus.SQ_VAL_OUT) begin
            if (tmo_hit) err_d = 1'b1;
            else         cnt_d = cnt_q + 7'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    logic tmo_unused;
    assign tmo_unused = (TMO_CYC == 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_vld) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus.SQ_VAL_OUT || tmo_hit) state_d = ST_RESP;
            ST_RESP:  if (bus.RSP_RDY[gnt_q]) state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.REQ_RDY    = (state_q == ST_IDLE) ? pick_gnt : '0;
        bus.RSP_VAL    = (state_q == ST_RESP) ? (NREQ'(1) << gnt_q) : '0;
        bus.RSP_DATA   = res_q;
        bus.SQ_VAL_IN  = (state_q == ST_ISSUE);
        bus.SQ_DATA_IN = op_q;
        BUSY           = (state_q != ST_IDLE);
`ifdef SBD_SQRT_ARB_TIMEOUT_EN
        ERR            = err_q;
`else
        ERR            = 1'b0;
`endif
    end

    always_comb begin
        ptr_d = ptr_q;
        gnt_d = gnt_q;
        op_d  = op_q;
        res_d = res_q;
        if (state_q == ST_IDLE && pick_vld) begin
            gnt_d = win_idx;
            ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
            op_d  = bus.REQ_DATA[win_idx*WIDTH +: WIDTH];
        end
        // results outside WAIT are stray pulses and must not disturb res_q
        if (state_q == ST_WAIT) begin
            if (bus.SQ_VAL_OUT) res_d = bus.SQ_DATA_OUT;
            else if (tmo_hit)   res_d = '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr_q <= '0;
            gnt_q <= '0;
            op_q  <= '0;
            res_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            op_q  <= op_d;
            res_q <= res_d;
        end
    end
endmodule

// File: tb/tb_sbd_sqrt_fp_arbiter.sv
// Self-checking bench: random operands, a sqrt-unit stub and a round-robin
// scoreboard derived from the arbitration rule.
module tb_sbd_sqrt_fp_arbiter;
    import sbd_sqrt_fp_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic BUSY, ERR;

    sbd_sqrt_fp_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    sbd_sqrt_fp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TMO_CYC(63)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus),
        .BUSY  (BUSY),
        .ERR   (ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int rr_ptr = 0;
    int n_arr[NREQ];

    logic        sq_en = 1'b1;
    logic        model_val = 1'b0;
    logic [31:0] model_data = '0;
    logic        inj_val = 1'b0;
    logic [31:0] inj_data = '0;
    int          sq_cnt = 0;
    logic [31:0] sq_pend = '0;

    assign bus.SQ_VAL_OUT  = model_val | inj_val;
    assign bus.SQ_DATA_OUT = inj_val ? inj_data : model_data;

    function automatic logic [31:0] int2fp(input int unsigned v);
        int p;
        logic [31:0] m;
        p = 0;
        for (int b = 0; b < 32; b++) if (v[b]) p = b;
        m = v << (23 - p);
        return {1'b0, 8'(p + 127), m[22:0]};
    endfunction

    function automatic int unsigned fp2int(input logic [31:0] x);
        int e;
        logic [31:0] m;
        e = int'(x[30:23]) - 127;
        m = {8'h00, 1'b1, x[22:0]};
        return m >> (23 - e);
    endfunction

    function automatic int unsigned isqrt(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    // sqrt unit stub: fixed latency, exact root of perfect-square integers
    always @(negedge CLK) begin
        model_val = 1'b0;
        if (sq_cnt > 0) begin
            sq_cnt--;
            if (sq_cnt == 0) begin
                model_val  = 1'b1;
                model_data = int2fp(isqrt(fp2int(sq_pend)));
            end
        end
        if (sq_en && bus.SQ_VAL_IN) begin
            sq_cnt  = SQRT_LAT;
            sq_pend = bus.SQ_DATA_IN;
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        bus.REQ_VAL  = '0;
        bus.REQ_DATA = '0;
        bus.RSP_RDY  = '1;
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        rr_ptr = 0;
        checks++;
        if ({bus.REQ_RDY, bus.RSP_VAL, bus.SQ_VAL_IN, BUSY, ERR} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b expected=0", {bus.REQ_RDY, bus.RSP_VAL, bus.SQ_VAL_IN, BUSY, ERR});
        end
        checks++;
        if (bus.SQ_DATA_IN !== '0 || bus.RSP_DATA !== '0) begin
            failures++;
            $display("FAIL reset_data sq_data_in=%h rsp_data=%h expected=0", bus.SQ_DATA_IN, bus.RSP_DATA);
        end
    endtask

    task automatic test_single();
        int c;
        bus.REQ_DATA[0 +: WIDTH] = 32'h4080_0000;
        bus.REQ_VAL = 4'b0001;
        #1;
        checks++;
        if (bus.REQ_RDY !== 4'b0001) begin
            failures++;
            $display("FAIL single_rdy got=%b expected=0001", bus.REQ_RDY);
        end
        rr_ptr = 1;
        tick();
        bus.REQ_VAL = '0;
        checks++;
        if (bus.SQ_VAL_IN !== 1'b1 || bus.SQ_DATA_IN !== 32'h4080_0000 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL single_issue val=%b data=%h busy=%b expected 1/40800000/1", bus.SQ_VAL_IN, bus.SQ_DATA_IN, BUSY);
        end
        tick();
        checks++;
        if (bus.SQ_VAL_IN !== 1'b0 || bus.SQ_DATA_IN !== 32'h4080_0000) begin
            failures++;
            $display("FAIL single_wait val=%b data=%h expected 0/40800000", bus.SQ_VAL_IN, bus.SQ_DATA_IN);
        end
        c = 0;
        while (!bus.SQ_VAL_OUT && c < 200) begin
            tick();
            c++;
        end
        checks++;
        if (bus.RSP_VAL !== '0) begin
            failures++;
            $display("FAIL single_early_rsp got=%b expected=0000", bus.RSP_VAL);
        end
        tick();
        checks++;
        if (bus.RSP_VAL !== 4'b0001 || bus.RSP_DATA !== 32'h4000_0000) begin
            failures++;
            $display("FAIL single_rsp val=%b data=%h expected 0001/40000000", bus.RSP_VAL, bus.RSP_DATA);
        end
        tick();
        checks++;
        if (BUSY !== 1'b1 || bus.RSP_VAL !== '0 || bus.SQ_VAL_IN !== 1'b0) begin
            failures++;
            $display("FAIL single_gap busy=%b rsp_val=%b sq_val=%b expected 1/0000/0", BUSY, bus.RSP_VAL, bus.SQ_VAL_IN);
        end
        tick();
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL single_idle busy=%b expected=0", BUSY);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] mask;
        int w, exp_n, c;
        for (int i = 0; i < NREQ; i++) begin
            n_arr[i] = $urandom_range(1, 4095);
            bus.REQ_DATA[i*WIDTH +: WIDTH] = int2fp(n_arr[i] * n_arr[i]);
        end
        for (int it = 0; it < 17; it++) begin
            mask = (it < 5) ? '1 : NREQ'($urandom_range(1, (1 << NREQ) - 1));
            bus.REQ_VAL = mask;
            #1;
            w = model_pick(mask, rr_ptr);
            exp_n = n_arr[w];
            checks++;
            if (bus.REQ_RDY !== onehot(w)) begin
                failures++;
                $display("FAIL rr_grant it=%0d got=%b expected=%b", it, bus.REQ_RDY, onehot(w));
            end
            rr_ptr = (w + 1) % NREQ;
            tick();
            n_arr[w] = $urandom_range(1, 4095);
            bus.REQ_DATA[w*WIDTH +: WIDTH] = int2fp(n_arr[w] * n_arr[w]);
            checks++;
            if (bus.REQ_RDY !== '0 || bus.SQ_VAL_IN !== 1'b1) begin
                failures++;
                $display("FAIL rr_issue it=%0d rdy=%b sq_val=%b expected 0000/1", it, bus.REQ_RDY, bus.SQ_VAL_IN);
            end
            c = 0;
            while (bus.RSP_VAL === '0 && c < 200) begin
                tick();
                c++;
            end
            checks++;
            if (bus.RSP_VAL !== onehot(w) || bus.RSP_DATA !== int2fp(exp_n)) begin
                failures++;
                $display("FAIL rr_resp it=%0d val=%b data=%h expected %b/%h", it, bus.RSP_VAL, bus.RSP_DATA, onehot(w), int2fp(exp_n));
            end
            tick();
            checks++;
            if (bus.REQ_RDY !== '0 || bus.SQ_VAL_IN !== 1'b0 || BUSY !== 1'b1) begin
                failures++;
                $display("FAIL rr_gap it=%0d rdy=%b sq_val=%b busy=%b expected 0000/0/1", it, bus.REQ_RDY, bus.SQ_VAL_IN, BUSY);
            end
            tick();
        end
        bus.REQ_VAL = '0;
    endtask

    task automatic test_backpressure();
        int w, w2, exp_n, c;
        logic [31:0] exp_d;
        bus.REQ_VAL = '1;
        #1;
        w = model_pick('1, rr_ptr);
        exp_n = n_arr[w];
        exp_d = int2fp(exp_n);
        checks++;
        if (bus.REQ_RDY !== onehot(w)) begin
            failures++;
            $display("FAIL bp_grant got=%b expected=%b", bus.REQ_RDY, onehot(w));
        end
        rr_ptr = (w + 1) % NREQ;
        bus.RSP_RDY = ~onehot(w);
        tick();
        n_arr[w] = $urandom_range(1, 4095);
        bus.REQ_DATA[w*WIDTH +: WIDTH] = int2fp(n_arr[w] * n_arr[w]);
        c = 0;
        while (bus.RSP_VAL === '0 && c < 200) begin
            tick();
            c++;
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus.RSP_VAL !== onehot(w) || bus.RSP_DATA !== exp_d || bus.REQ_RDY !== '0 || BUSY !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold k=%0d val=%b data=%h rdy=%b busy=%b expected %b/%h/0000/1", k, bus.RSP_VAL, bus.RSP_DATA, bus.REQ_RDY, BUSY, onehot(w), exp_d);
            end
            inj_val  = (k == 4);
            inj_data = $urandom;
            tick();
        end
        inj_val = 1'b0;
        bus.RSP_RDY = '1;
        tick();
        checks++;
        if (bus.SQ_VAL_IN !== 1'b0 || bus.REQ_RDY !== '0 || bus.RSP_VAL !== '0) begin
            failures++;
            $display("FAIL bp_gap sq_val=%b rdy=%b rsp_val=%b expected 0/0000/0000", bus.SQ_VAL_IN, bus.REQ_RDY, bus.RSP_VAL);
        end
        tick();
        w2 = model_pick('1, rr_ptr);
        checks++;
        if (bus.REQ_RDY !== onehot(w2)) begin
            failures++;
            $display("FAIL bp_next_grant got=%b expected=%b", bus.REQ_RDY, onehot(w2));
        end
        bus.REQ_VAL = '0;
    endtask

    task automatic test_timeout();
        int w, bad;
        sq_en = 1'b0;
        bus.REQ_DATA[0 +: WIDTH] = 32'h4110_0000;
        bus.REQ_VAL = 4'b0001;
        #1;
        w = model_pick(4'b0001, rr_ptr);
        checks++;
        if (bus.REQ_RDY !== onehot(w)) begin
            failures++;
            $display("FAIL tmo_grant got=%b expected=%b", bus.REQ_RDY, onehot(w));
        end
        rr_ptr = (w + 1) % NREQ;
        tick();
        bus.REQ_VAL = '0;
        bad = 0;
`ifdef SBD_SQRT_ARB_TIMEOUT_EN
        for (int k = 1; k <= 63; k++) begin
            tick();
            if (bus.RSP_VAL !== '0 || ERR !== 1'b0 || BUSY !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL tmo_wait bad_cycles=%0d expected=0", bad);
        end
        tick();
        checks++;
        if (bus.RSP_VAL !== onehot(w) || ERR !== 1'b1 || bus.RSP_DATA !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL tmo_fire val=%b err=%b data=%h expected %b/1/ffffffff", bus.RSP_VAL, ERR, bus.RSP_DATA, onehot(w));
        end
        tick();
        tick();
        checks++;
        if (ERR !== 1'b1 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL tmo_sticky err=%b busy=%b expected 1/0", ERR, BUSY);
        end
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.RSP_VAL !== '0 || ERR !== 1'b0 || BUSY !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL wait_forever bad_cycles=%0d expected=0", bad);
        end
`endif
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        rr_ptr = 0;
        sq_en = 1'b1;
        checks++;
        if (ERR !== 1'b0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL tmo_reset err=%b busy=%b expected 0/0", ERR, BUSY);
        end
    endtask

    task automatic test_reset_mid_wait();
        int w, bad;
        bus.REQ_DATA[1*WIDTH +: WIDTH] = int2fp(16);
        bus.REQ_VAL = 4'b0010;
        #1;
        w = model_pick(4'b0010, rr_ptr);
        checks++;
        if (bus.REQ_RDY !== onehot(w)) begin
            failures++;
            $display("FAIL rstw_grant got=%b expected=%b", bus.REQ_RDY, onehot(w));
        end
        tick();
        bus.REQ_VAL = '0;
        for (int k = 1; k <= 5; k++) tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        rr_ptr = 0;
        checks++;
        if ({bus.REQ_RDY, bus.RSP_VAL, bus.SQ_VAL_IN, BUSY, ERR} !== '0 || bus.SQ_DATA_IN !== '0 || bus.RSP_DATA !== '0) begin
            failures++;
            $display("FAIL rstw_outputs ctrl=%b sq_data=%h rsp_data=%h expected all 0", {bus.REQ_RDY, bus.RSP_VAL, bus.SQ_VAL_IN, BUSY, ERR}, bus.SQ_DATA_IN, bus.RSP_DATA);
        end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.RSP_VAL !== '0 || BUSY !== 1'b0 || bus.RSP_DATA !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rstw_late_rsp bad_cycles=%0d expected=0", bad);
        end
    endtask

    task automatic test_spurious();
        int w;
        inj_data = $urandom;
        inj_val  = 1'b1;
        tick();
        inj_val = 1'b0;
        tick();
        checks++;
        if (BUSY !== 1'b0 || bus.RSP_VAL !== '0 || bus.RSP_DATA !== '0 || bus.SQ_VAL_IN !== 1'b0) begin
            failures++;
            $display("FAIL spurious_idle busy=%b rsp_val=%b rsp_data=%h sq_val=%b expected 0/0000/0/0", BUSY, bus.RSP_VAL, bus.RSP_DATA, bus.SQ_VAL_IN);
        end
        bus.REQ_VAL = '1;
        #1;
        w = model_pick('1, rr_ptr);
        checks++;
        if (bus.REQ_RDY !== onehot(w)) begin
            failures++;
            $display("FAIL spurious_grant got=%b expected=%b", bus.REQ_RDY, onehot(w));
        end
        bus.REQ_VAL = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_spurious();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/sbd_sqrt_fp_arbiter.md
Name: sbd_sqrt_fp_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sbd_sqrt_fp32 unit between NREQ requesters.
- Accepts operands over per-requester valid/ready handshakes and issues exactly one operation at a time to the sqrt unit.
- Holds the operand stable for the whole operation and returns the result to the granted requester through a buffered response handshake.
- Sits between the ALU issue logic and the sqrt datapath in the processor ALU module.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width in bits.
- TMO_CYC, 63, watchdog limit in cycles (used only with the optional feature).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- REQ_VAL  in  NREQ  per-requester operand valid.
- REQ_DATA  in  NREQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH].
- REQ_RDY  out  NREQ  one-hot accept; a handshake occurs when REQ_VAL[i] & REQ_RDY[i].
- RSP_VAL  out  NREQ  one-hot result valid, addressed to the granted requester.
- RSP_RDY  in  NREQ  per-requester result accept.
- RSP_DATA  out  WIDTH  result, shared by all requesters; qualified by RSP_VAL.
- SQ_VAL_IN  out  1  start pulse to the sqrt unit.
- SQ_DATA_IN  out  WIDTH  operand to the sqrt unit.
- SQ_VAL_OUT  in  1  sqrt unit result valid.
- SQ_DATA_OUT  in  WIDTH  sqrt unit result.
- BUSY  out  1  high in any state other than IDLE.
- ERR  out  1  sticky timeout flag (tied to 0 without the optional feature).

Behaviour:
- Reset (RST_N=0 at a clock edge):
  - State goes to IDLE.
  - REQ_RDY, RSP_VAL, SQ_VAL_IN, BUSY and ERR are 0; SQ_DATA_IN and RSP_DATA are 0.
  - Round-robin pointer goes to 0.
  - Reset mid-operation abandons the operation. Any later SQ_VAL_OUT arriving while in IDLE or GAP is ignored.
- States: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - Arbitration is combinational: the winner is the first i with REQ_VAL[i]=1, searching upward from the pointer with wrap-around.
  - REQ_RDY is asserted only to the winner, in the same cycle.
  - On handshake: capture the operand into the operand register, capture the winner index into the grant register, set pointer = winner+1 mod NREQ, go to ISSUE.
  - With no REQ_VAL asserted, stay in IDLE.
- ISSUE: SQ_VAL_IN=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - SQ_VAL_IN=0. SQ_DATA_IN continues to drive the operand register (stable from ISSUE until leaving WAIT).
  - When SQ_VAL_OUT=1: capture SQ_DATA_OUT into the result register, go to RESP.
- RESP:
  - RSP_VAL[grant]=1; RSP_DATA = result register.
  - Remain in RESP until RSP_RDY[grant]=1. RSP_RDY of non-granted requesters is ignored.
  - On accept, go to GAP.
- GAP:
  - One cycle with SQ_VAL_IN=0; guarantees the sqrt unit's internal valid state clears before the next start.
  - Then go to IDLE.
- REQ_RDY is 0 in every state except IDLE, so there is no new acceptance while busy.
- Latency:
  - Request accept to SQ_VAL_IN: 1 cycle.
  - SQ_VAL_OUT to RSP_VAL: 1 cycle.
  - Minimum spacing between accepts: sqrt latency + 4 cycles.
- Simultaneous requests: exactly one grant per arbitration; the pointer guarantees fairness.
- REQ_VAL deasserted before the handshake: no grant, no state change.
- A spurious SQ_VAL_OUT in IDLE, ISSUE, RESP or GAP is ignored.

Optional Feature:
- Macro: SBD_SQRT_ARB_TIMEOUT_EN.
- Defined:
  - A 7-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches TMO_CYC without SQ_VAL_OUT, set ERR (sticky until reset), load result = all ones, go to RESP.
- Undefined: no counter; ERR is constant 0; WAIT lasts indefinitely.

Decomposition:
- Shared package sbd_sqrt_fp_pkg holds:
  - state encoding constants ST_IDLE..ST_GAP;
  - default WIDTH;
  - sqrt unit nominal latency constant SQRT_LAT = 27, used by the bench and checkers.
- One sub-module: sbd_rr_pick, a combinational round-robin priority picker (inputs: request vector, pointer; output: one-hot grant plus valid).

Test Plan:
- Single request: REQ_VAL=0001, operand 0x40800000 (4.0) with a sqrt model responding after 27 cycles.
  - REQ_RDY[0] is high the same cycle.
  - SQ_VAL_IN pulses 1 cycle later.
  - RSP_VAL=0001 with RSP_DATA=0x40000000 one cycle after SQ_VAL_OUT.
- All four requesting continuously: grants occur in order 0,1,2,3,0; every requester receives its own result.
- Response backpressure: RSP_RDY[grant] held low for 10 cycles.
  - RSP_VAL and RSP_DATA are stable throughout.
  - REQ_RDY stays 0.
  - GAP is observed (SQ_VAL_IN=0) before the next accept.
- Reset mid-WAIT: RST_N=0 for 1 cycle at WAIT cycle 5.
  - All outputs read 0 next cycle.
  - A late SQ_VAL_OUT produces no RSP_VAL.
- With SBD_SQRT_ARB_TIMEOUT_EN and TMO_CYC=63: no SQ_VAL_OUT.
  - After 63 WAIT cycles ERR=1 and RSP_DATA=0xFFFFFFFF.
  - ERR stays 1 after the response is accepted.
- Spurious SQ_VAL_OUT while in IDLE: no state change, no RSP_VAL.
